adder_rr_arbiter: RTL

Shares one 8-bit pipelined adder (adder_8b_pipeline, one-cycle latency) between NUM_REQ requesters.
- Grants at most one request per cycle, round-robin, using a valid/ready handshake.
- Drives the adder operands and carries the winner's ID through a tag pipeline matched to the adder latency.
- Returns each result tagged with its requester ID.
- Sits between client blocks (ALU sequencers, accumulators) and the shared adder instance.

---
 rtl/adder_arb_pkg.sv | 37 +++
 rtl/adder_8b_pipeline.sv | 21 ++
 rtl/rr_grant.sv | 35 +++
 rtl/adder_rr_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared constants and round-robin search helper for the adder arbiter.
// Pure combinational function; no state, no backpressure.
package adder_arb_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam int MAX_REQ     = 8;
  localparam int MAX_IDW     = 3;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate the index back.
  function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0] valid,
                                         input logic [MAX_IDW-1:0] ptr,
                                         input int                 n);
    logic [MAX_REQ-1:0] rot;
    logic [MAX_IDW-1:0] src;
    rr_pick_t           pick;
    rot  = '0;
    pick = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      src = MAX_IDW'((int'(ptr) + k) % n);
      if (k < n) rot[k] = valid[src];
    end
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick.found = 1'b1;
        pick.idx   = MAX_IDW'((int'(ptr) + k) % n);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder_8b_pipeline.sv
// 8-bit adder with one registered stage; sum/cout valid one cycle after operands.
// No stall input: every cycle's operands produce a result.
module adder_8b_pipeline (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cout, sum} <= '0;
    end else begin
      {cout, sum} <= {1'b0, a} + {1'b0, b} + {8'b0, cin};
    end
  end

endmodule

// File: rtl/rr_grant.sv
// Round-robin grant: holds rr_ptr, emits one-hot grant and encoded winner.
// Grant is combinational in the request cycle; pointer advances on the next edge.
module rr_grant
  import adder_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_any
);

  logic [IDW-1:0] rr_ptr;
  rr_pick_t       pick;

  always_comb pick = rr_search(MAX_REQ'(req_valid), MAX_IDW'(rr_ptr), NUM_REQ);

  // Grants are suppressed while reset is held so nothing is issued to the adder.
  assign grant_any = pick.found & ~rst;
  assign grant_idx = IDW'(pick.idx);
  assign grant     = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one pipelined adder among NUM_REQ requesters, round-robin, one op per cycle.
// Result returns LATENCY cycles after grant; responses cannot be back-pressured.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  WIDTH   = DEF_WIDTH,
  parameter int  LATENCY = 1,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
);

  logic           grant_any;
  logic [IDW-1:0] grant_idx;

  rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // One-hot select; operands stay at zero when idle to keep the adder quiet.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        add_a   = req_a[i*WIDTH +: WIDTH];
        add_b   = req_b[i*WIDTH +: WIDTH];
        add_cin = req_cin[i];
      end
    end
  end

  logic [LATENCY-1:0] tag_vld;
  logic [IDW-1:0]     tag_id [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int s = 0; s < LATENCY; s++) tag_id[s] <= '0;
    end else begin
      tag_vld[0] <= grant_any;
      tag_id[0]  <= grant_idx;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign rsp_valid = tag_vld[LATENCY-1];
  assign rsp_id    = tag_id[LATENCY-1];
  assign rsp_sum   = add_sum;
  assign rsp_cout  = add_cout;
  assign busy      = |tag_vld;

endmodule
